// File: rtl/ppc_types.sv
// ppc_types: shared decode types plus dispatch routing and side-band flag helpers
package ppc_types;

    typedef enum logic [3:0] {
        EXEC_ADD_SUB,
        EXEC_MUL,
        EXEC_DIV,
        EXEC_LOGICAL,
        EXEC_ROTATE,
        EXEC_COMPARE,
        EXEC_SYSTEM,
        EXEC_TRAP,
        EXEC_LOAD,
        EXEC_STORE,
        EXEC_BRANCH,
        EXEC_NONE
    } exec_unit_e;

    typedef enum logic [2:0] {
        SYS_NONE,
        SYS_MTSPR,
        SYS_MFSPR,
        SYS_MTCR,
        SYS_MFCR
    } sys_op_e;

    typedef struct packed {
        exec_unit_e execute;
        logic       alter_OV;
        logic       alter_CA;
        logic       add_CA;
        logic       alter_CR0;
        logic       shift;
        logic       left;
        logic       sign_extend;
        sys_op_e    sys_op;
    } fixed_point_t;

    typedef struct packed {
        logic [31:0]  pc;
        logic [4:0]   rt;
        logic [4:0]   ra;
        logic [4:0]   rb;
        logic [15:0]  imm;
        fixed_point_t fixed_point;
    } decode_result_t;

    localparam int UNIT_W = 5;
    typedef logic [UNIT_W-1:0] unit_idx_t;

    localparam unit_idx_t UNIT_ADD_SUB = 5'd0;
    localparam unit_idx_t UNIT_MUL     = 5'd1;
    localparam unit_idx_t UNIT_DIV     = 5'd2;
    localparam unit_idx_t UNIT_LOGICAL = 5'd3;
    localparam unit_idx_t UNIT_ROTATE  = 5'd4;
    localparam unit_idx_t UNIT_COMPARE = 5'd5;
    localparam unit_idx_t UNIT_SYSTEM  = 5'd6;
    localparam unit_idx_t UNIT_TRAP    = 5'd7;
    localparam unit_idx_t UNIT_INVALID = 5'h1F;

    typedef struct packed {
        logic write_to_gpr;
        logic write_to_spr;
        logic write_to_cr;
        logic alter_xer;
        logic alter_CR0;
        logic read_xer;
    } dispatch_flags_t;

    typedef struct packed {
        decode_result_t  decode;
        unit_idx_t       unit;
        dispatch_flags_t flags;
    } dispatch_entry_t;

    function automatic unit_idx_t exec_to_unit(input decode_result_t d);
        unit_idx_t u;
        case (d.fixed_point.execute)
            EXEC_ADD_SUB: u = UNIT_ADD_SUB;
            EXEC_MUL:     u = UNIT_MUL;
            EXEC_DIV:     u = UNIT_DIV;
            EXEC_LOGICAL: u = UNIT_LOGICAL;
            EXEC_ROTATE:  u = UNIT_ROTATE;
            EXEC_COMPARE: u = UNIT_COMPARE;
            EXEC_SYSTEM:  u = UNIT_SYSTEM;
            EXEC_TRAP:    u = UNIT_TRAP;
            default:      u = UNIT_INVALID;
        endcase
        return u;
    endfunction

    function automatic dispatch_flags_t dispatch_flags(input decode_result_t d);
        dispatch_flags_t r;
        fixed_point_t    f;
        r = '0;
        f = d.fixed_point;
        case (f.execute)
            EXEC_ADD_SUB: begin
                r.write_to_gpr = 1'b1;
                r.alter_xer    = f.alter_OV | f.alter_CA;
                r.alter_CR0    = f.alter_CR0;
                r.read_xer     = f.add_CA | f.alter_OV | f.alter_CR0;
            end
            EXEC_MUL, EXEC_DIV: begin
                r.write_to_gpr = 1'b1;
                r.alter_xer    = f.alter_OV;
                r.alter_CR0    = f.alter_CR0;
                r.read_xer     = f.alter_CR0;
            end
            EXEC_LOGICAL: begin
                r.write_to_gpr = 1'b1;
                r.alter_CR0    = f.alter_CR0;
                r.read_xer     = f.alter_CR0;
            end
            EXEC_ROTATE: begin
                r.write_to_gpr = 1'b1;
                // only algebraic right shifts touch XER (carry out)
                r.alter_xer    = f.shift & !f.left & f.sign_extend;
                r.alter_CR0    = f.alter_CR0;
                r.read_xer     = f.alter_CR0;
            end
            EXEC_COMPARE: begin
                r.write_to_cr = 1'b1;
                r.read_xer    = 1'b1;
            end
            EXEC_SYSTEM: begin
                r.write_to_gpr = (f.sys_op == SYS_MFSPR) || (f.sys_op == SYS_MFCR);
                r.write_to_spr = f.sys_op == SYS_MTSPR;
                r.write_to_cr  = f.sys_op == SYS_MTCR;
            end
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dispatch_fifo.sv
// dispatch_fifo: in-order queue of generic entries with flush and occupancy
module dispatch_fifo #(
    parameter type T     = logic,
    parameter int  DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        push,
    input  logic        pop,
    input  T            din,
    output T            dout,
    output logic        full,
    output logic        empty,
    output logic [AW:0] occupancy
);

    T              r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign full      = r_count == (AW+1)'(DEPTH);
    assign empty     = r_count == '0;
    assign occupancy = r_count;
    assign dout      = r_mem[r_rd];
    assign w_push    = push && !full && !flush;
    assign w_pop     = pop && !empty && !flush;

    // storage needs no reset; occupancy decides which slots are meaningful
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= din;
    end

    // pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + AW'(1);
            if (w_pop) r_rd <= r_rd + AW'(1);
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

endmodule

// File: rtl/dispatch_buffer.sv
// dispatch_buffer: queues decoded instructions and issues the head to its execution unit
module dispatch_buffer
    import ppc_types::*;
#(
    parameter int  RS_ID_WIDTH = 5,
    parameter int  NUM_UNITS   = 8,
    parameter int  DEPTH       = 4,
    localparam int OW          = $clog2(DEPTH) + 1
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 flush,
    input  logic                                 input_valid,
    output logic                                 input_ready,
    input  decode_result_t                       decode,
    output logic [NUM_UNITS-1:0]                 unit_valid,
    input  logic [NUM_UNITS-1:0]                 unit_ready,
    output decode_result_t                       unit_decode,
    input  logic [NUM_UNITS-1:0][RS_ID_WIDTH-1:0] unit_id,
    output logic                                 dispatched,
    output logic [RS_ID_WIDTH-1:0]               id_taken,
    output logic                                 write_to_gpr,
    output logic                                 write_to_spr,
    output logic                                 write_to_cr,
    output logic                                 alter_xer,
    output logic                                 alter_CR0,
    output logic                                 read_xer,
    output logic                                 invalid_instr,
    output logic [15:0]                          invalid_count,
    output logic [OW-1:0]                        occupancy
);

    unit_idx_t             w_unit_raw;
    unit_idx_t             w_unit;
    dispatch_flags_t       w_flags;
    dispatch_entry_t       w_in;
    dispatch_entry_t       w_head;
    dispatch_flags_t       w_flags_out;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_active;
    logic                  w_inv;
    logic                  w_issue;
    logic                  w_sel_ready;
    logic [NUM_UNITS-1:0]  w_match;
    logic [RS_ID_WIDTH-1:0] w_id;
    logic [15:0]           r_invalid_count;

    // routing and flags are resolved at enqueue so the issue path is just a lookup
    assign w_unit_raw = exec_to_unit(decode);
    assign w_unit     = (int'(w_unit_raw) >= NUM_UNITS) ? UNIT_INVALID : w_unit_raw;
    assign w_flags    = (w_unit == UNIT_INVALID) ? '0 : dispatch_flags(decode);
    assign w_in       = '{decode: decode, unit: w_unit, flags: w_flags};

    assign input_ready = !w_full;
    assign w_push      = input_valid && !w_full && !flush;

    dispatch_fifo #(
        .T     (dispatch_entry_t),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .push      (w_push),
        .pop       (w_pop),
        .din       (w_in),
        .dout      (w_head),
        .full      (w_full),
        .empty     (w_empty),
        .occupancy (occupancy)
    );

    // decode the head's unit index into a select vector, its ready and its allocated ID
    always_comb begin
        w_match     = '0;
        w_sel_ready = 1'b0;
        w_id        = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            w_match[i]  = w_head.unit == UNIT_W'(i);
            w_sel_ready = w_sel_ready | (w_match[i] & unit_ready[i]);
            w_id        = w_id | (w_match[i] ? unit_id[i] : '0);
        end
    end

    assign w_active      = !w_empty && !flush;
    assign w_inv         = w_head.unit == UNIT_INVALID;
    assign w_issue       = w_active && !w_inv;
    assign unit_valid    = w_issue ? w_match : '0;
    assign dispatched    = w_issue && w_sel_ready;
    assign invalid_instr = w_active && w_inv;
    assign w_pop         = dispatched || invalid_instr;
    assign unit_decode   = w_head.decode;
    assign id_taken      = dispatched ? w_id : '0;
    assign w_flags_out   = dispatched ? w_head.flags : '0;
    assign write_to_gpr  = w_flags_out.write_to_gpr;
    assign write_to_spr  = w_flags_out.write_to_spr;
    assign write_to_cr   = w_flags_out.write_to_cr;
    assign alter_xer     = w_flags_out.alter_xer;
    assign alter_CR0     = w_flags_out.alter_CR0;
    assign read_xer      = w_flags_out.read_xer;
    assign invalid_count = r_invalid_count;

    // count invalid retirements, sticking at all-ones; flush leaves it alone
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_invalid_count <= '0;
        end else if (invalid_instr && r_invalid_count != 16'hFFFF) begin
            r_invalid_count <= r_invalid_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_dispatch_buffer.sv
// tb_dispatch_buffer: directed checks of queueing, routing, invalid retire, flush and reset
module tb_dispatch_buffer;
    import ppc_types::*;

    logic                clk;
    logic                rst_n;
    logic                flush;
    logic                input_valid;
    logic                input_ready;
    decode_result_t      decode;
    logic [7:0]          unit_valid;
    logic [7:0]          unit_ready;
    decode_result_t      unit_decode;
    logic [7:0][4:0]     unit_id;
    logic                dispatched;
    logic [4:0]          id_taken;
    logic                write_to_gpr;
    logic                write_to_spr;
    logic                write_to_cr;
    logic                alter_xer;
    logic                alter_CR0;
    logic                read_xer;
    logic                invalid_instr;
    logic [15:0]         invalid_count;
    logic [2:0]          occupancy;

    int tests = 0;
    int fails = 0;

    dispatch_buffer #(.RS_ID_WIDTH(5), .NUM_UNITS(8), .DEPTH(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .input_valid   (input_valid),
        .input_ready   (input_ready),
        .decode        (decode),
        .unit_valid    (unit_valid),
        .unit_ready    (unit_ready),
        .unit_decode   (unit_decode),
        .unit_id       (unit_id),
        .dispatched    (dispatched),
        .id_taken      (id_taken),
        .write_to_gpr  (write_to_gpr),
        .write_to_spr  (write_to_spr),
        .write_to_cr   (write_to_cr),
        .alter_xer     (alter_xer),
        .alter_CR0     (alter_CR0),
        .read_xer      (read_xer),
        .invalid_instr (invalid_instr),
        .invalid_count (invalid_count),
        .occupancy     (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic decode_result_t mk(input exec_unit_e e);
        decode_result_t r;
        r = '0;
        r.fixed_point.execute = e;
        return r;
    endfunction

    decode_result_t d;

    initial begin
        rst_n       = 1'b0;
        flush       = 1'b0;
        input_valid = 1'b0;
        decode      = '0;
        unit_ready  = '0;
        for (int i = 0; i < 8; i++) unit_id[i] = 5'(9 + i);
        #12;
        chk("rst_occupancy", 32'(occupancy), 0);
        chk("rst_input_ready", 32'(input_ready), 1);
        chk("rst_unit_valid", 32'(unit_valid), 0);
        chk("rst_dispatched", 32'(dispatched), 0);
        chk("rst_invalid_instr", 32'(invalid_instr), 0);
        chk("rst_id_taken", 32'(id_taken), 0);
        chk("rst_invalid_count", 32'(invalid_count), 0);
        chk("rst_flags", 32'({write_to_gpr, write_to_spr, write_to_cr, alter_xer, alter_CR0, read_xer}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();

        // single ADD_SUB with alter_OV
        d = mk(EXEC_ADD_SUB);
        d.fixed_point.alter_OV = 1'b1;
        decode      = d;
        input_valid = 1'b1;
        unit_ready  = 8'hFF;
        #1;
        chk("no_same_cycle_issue", 32'(unit_valid), 0);
        cyc();
        input_valid = 1'b0;
        #1;
        chk("single_unit_valid", 32'(unit_valid), 32'h01);
        chk("single_dispatched", 32'(dispatched), 1);
        chk("single_id_taken", 32'(id_taken), 9);
        chk("single_gpr", 32'(write_to_gpr), 1);
        chk("single_alter_xer", 32'(alter_xer), 1);
        chk("single_read_xer", 32'(read_xer), 1);
        chk("single_write_cr", 32'(write_to_cr), 0);
        cyc();
        chk("single_drained", 32'(occupancy), 0);

        // backpressure fill with six LOGICAL pushes tagged by rt
        unit_ready = 8'h00;
        for (int i = 0; i < 6; i++) begin
            d = mk(EXEC_LOGICAL);
            d.rt = 5'(i + 1);
            decode      = d;
            input_valid = 1'b1;
            #1;
            chk($sformatf("fill_ready_%0d", i), 32'(input_ready), 32'(i < 4));
            cyc();
        end
        input_valid = 1'b0;
        #1;
        chk("full_occupancy", 32'(occupancy), 4);
        chk("full_input_ready", 32'(input_ready), 0);
        chk("blocked_unit_valid", 32'(unit_valid), 32'h08);
        chk("blocked_head_rt", 32'(unit_decode.rt), 1);
        unit_ready = 8'hF7;
        #1;
        chk("other_ready_ignored", 32'(dispatched), 0);
        cyc();
        chk("still_full", 32'(occupancy), 4);
        unit_ready  = 8'h08;
        input_valid = 1'b1;
        #1;
        chk("no_pop_push_bypass", 32'(input_ready), 0);
        input_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("drain_disp_%0d", k), 32'(dispatched), 1);
            chk($sformatf("drain_rt_%0d", k), 32'(unit_decode.rt), 32'(k + 1));
            chk($sformatf("drain_id_%0d", k), 32'(id_taken), 12);
            cyc();
        end
        chk("drain_empty", 32'(occupancy), 0);

        // invalid retire
        decode      = mk(EXEC_LOAD);
        input_valid = 1'b1;
        cyc();
        input_valid = 1'b0;
        #1;
        chk("inv_pulse", 32'(invalid_instr), 1);
        chk("inv_unit_valid", 32'(unit_valid), 0);
        chk("inv_dispatched", 32'(dispatched), 0);
        cyc();
        chk("inv_count_1", 32'(invalid_count), 1);
        chk("inv_popped", 32'(occupancy), 0);

        // flush with three queued and input_valid high
        unit_ready  = 8'h00;
        decode      = mk(EXEC_LOGICAL);
        input_valid = 1'b1;
        repeat (3) cyc();
        flush      = 1'b1;
        unit_ready = 8'hFF;
        #1;
        chk("pre_flush_occ", 32'(occupancy), 3);
        chk("flush_unit_valid", 32'(unit_valid), 0);
        chk("flush_dispatched", 32'(dispatched), 0);
        chk("flush_invalid", 32'(invalid_instr), 0);
        cyc();
        flush       = 1'b0;
        input_valid = 1'b0;
        #1;
        chk("post_flush_occ", 32'(occupancy), 0);
        chk("post_flush_count", 32'(invalid_count), 1);

        // mixed routing: MUL, COMPARE, SYSTEM mtspr, ROTATE sraw
        unit_ready  = 8'h00;
        input_valid = 1'b1;
        decode = mk(EXEC_MUL);
        cyc();
        decode = mk(EXEC_COMPARE);
        cyc();
        d = mk(EXEC_SYSTEM);
        d.fixed_point.sys_op = SYS_MTSPR;
        decode = d;
        cyc();
        d = mk(EXEC_ROTATE);
        d.fixed_point.shift       = 1'b1;
        d.fixed_point.sign_extend = 1'b1;
        decode = d;
        cyc();
        input_valid = 1'b0;
        unit_ready  = 8'hFF;
        #1;
        chk("mul_unit", 32'(unit_valid), 32'h02);
        chk("mul_gpr", 32'(write_to_gpr), 1);
        chk("mul_id", 32'(id_taken), 10);
        cyc();
        chk("cmp_unit", 32'(unit_valid), 32'h20);
        chk("cmp_write_cr", 32'(write_to_cr), 1);
        chk("cmp_read_xer", 32'(read_xer), 1);
        chk("cmp_gpr", 32'(write_to_gpr), 0);
        cyc();
        chk("sys_unit", 32'(unit_valid), 32'h40);
        chk("sys_write_spr", 32'(write_to_spr), 1);
        chk("sys_gpr", 32'(write_to_gpr), 0);
        cyc();
        chk("rot_unit", 32'(unit_valid), 32'h10);
        chk("rot_alter_xer", 32'(alter_xer), 1);
        chk("rot_gpr", 32'(write_to_gpr), 1);
        chk("rot_read_xer", 32'(read_xer), 0);
        cyc();
        chk("mixed_empty", 32'(occupancy), 0);

        // saturate the invalid counter: 1 + 65534 = 0xFFFF, then one more
        decode      = mk(EXEC_LOAD);
        input_valid = 1'b1;
        repeat (65534) cyc();
        input_valid = 1'b0;
        cyc();
        chk("sat_reach", 32'(invalid_count), 32'hFFFF);
        input_valid = 1'b1;
        cyc();
        input_valid = 1'b0;
        #1;
        chk("sat_pulse", 32'(invalid_instr), 1);
        cyc();
        chk("sat_hold", 32'(invalid_count), 32'hFFFF);

        // asynchronous reset between edges with two queued
        unit_ready  = 8'h00;
        decode      = mk(EXEC_DIV);
        input_valid = 1'b1;
        repeat (2) cyc();
        input_valid = 1'b0;
        #1;
        chk("pre_arst_occ", 32'(occupancy), 2);
        chk("pre_arst_valid", 32'(unit_valid), 32'h04);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_unit_valid", 32'(unit_valid), 0);
        chk("arst_occupancy", 32'(occupancy), 0);
        chk("arst_input_ready", 32'(input_ready), 1);
        chk("arst_count", 32'(invalid_count), 0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dispatch_buffer.md
# dispatch_buffer

Buffered, parametrised instruction dispatcher between instruction decode and the fixed-point execution units. It accepts one `decode_result_t` per cycle into a DEPTH-entry in-order queue and precomputes the routing unit index and register-file side-band flags at enqueue. The queue head is issued to the selected unit's reservation station under valid/ready. Invalid instructions are retired without issue, counted, and flagged for the trap logic.

## Interface
- `RS_ID_WIDTH`, 5: width of reservation-station IDs.
- `NUM_UNITS`, 8: number of unit channels. Any unit index ≥ NUM_UNITS is treated as invalid.
- `DEPTH`, 4: queue entries; power of two, ≥ 2.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `flush` in 1: synchronous queue clear.
- `input_valid` in 1: decode slot valid.
- `input_ready` out 1: equals `!full`.
- `decode` in `decode_result_t`: decoded instruction.
- `unit_valid` out [NUM_UNITS]: per-unit issue request; one-hot or zero.
- `unit_ready` in [NUM_UNITS]: per-unit accept.
- `unit_decode` out `decode_result_t`: head payload, broadcast to all units.
- `unit_id` in [NUM_UNITS][RS_ID_WIDTH]: ID each unit will allocate.
- `dispatched` out 1: head issued this cycle.
- `id_taken` out RS_ID_WIDTH: `unit_id[head.unit]` when `dispatched`, else 0.
- `write_to_gpr`, `write_to_spr`, `write_to_cr`, `alter_xer`, `alter_CR0`, `read_xer` out 1 each: head flags, qualified by `dispatched`.
- `invalid_instr` out 1: pulse when an invalid head is retired.
- `invalid_count` out 16: saturating count of invalid retirements.
- `occupancy` out clog2(DEPTH)+1: number of entries in the queue.

## Operation
- **Enqueue:** happens when `input_valid && input_ready && !flush`. The stored entry is `{decode, exec_to_unit(decode), dispatch_flags(decode)}`.
- **Unit mapping** (`fixed_point.execute`):
  - ADD_SUB → 0, MUL → 1, DIV → 2, LOGICAL → 3, ROTATE → 4, COMPARE → 5, SYSTEM → 6, TRAP → 7.
  - All other codes, or an index ≥ NUM_UNITS, map to INVALID.
- **Flags:**
  - `write_to_gpr`: add/mul/div/log/rot, plus sys move-from-SPR or move-from-CR.
  - `write_to_spr`: sys move-to-SPR.
  - `write_to_cr`: compare or sys move-to-CR.
  - `alter_xer`:
    - add_sub: OV | CA.
    - mul/div: OV.
    - rotate: shift & !left & sign_extend.
  - `alter_CR0`: the unit's alter_CR0 field.
  - `read_xer`:
    - add_sub: add_CA | alter_OV | alter_CR0.
    - mul/div/log/rot: alter_CR0.
    - compare: 1.
  - Trap, invalid and all remaining cases: every flag is 0.
- **Issue (non-empty queue, `!flush`):**
  - `unit_valid[head.unit] = 1`; all other bits are 0.
  - The head pops when `unit_ready[head.unit]` is high; `dispatched` pulses in the same cycle.
  - While waiting, the head holds stable: no reordering, no bypass of a blocked head.
- **Invalid head:** pops unconditionally in one cycle. It raises `invalid_instr`, no `unit_valid` bit, and `dispatched = 0`. `invalid_count` increments and saturates at 0xFFFF.
- **Flush:**
  - Occupancy is 0 in the next cycle.
  - During the flush cycle, `unit_valid`, `dispatched` and `invalid_instr` are forced to 0 and no enqueue occurs.
  - `invalid_count` is preserved.
- **Reset values:** all `unit_valid` 0, `dispatched` 0, `invalid_instr` 0, `id_taken` 0, all flags 0, `invalid_count` 0, `occupancy` 0, `input_ready` 1.

## Timing
- Enqueue-to-issue latency is 1 cycle minimum; there is no same-cycle input-to-unit bypass.
- Throughput is 1 instruction/cycle sustained when the target unit is ready.
- Full queue: `input_ready = 0`, even if the head pops in the same cycle (no pop-to-push bypass). The freed slot is visible one cycle later.
- Empty queue: all `unit_valid` are 0. A same-cycle enqueue is not issued.
- Pointers wrap modulo DEPTH. Occupancy distinguishes full from empty.
- `unit_ready` for non-selected units is ignored.
- `rst_n` asserted mid-operation clears the queue and counter immediately, without waiting for a clock edge.

## Structure
- **Shared package `ppc_types`** gains:
  - unit index constants UNIT_ADD_SUB … UNIT_TRAP and UNIT_INVALID;
  - `dispatch_flags_t` (the six flags);
  - `dispatch_entry_t`;
  - functions `exec_to_unit` and `dispatch_flags`.
- **Sub-module `dispatch_fifo`:** generic synchronous FIFO parametrised in entry type and DEPTH, with push/pop/flush/full/empty/occupancy.
- **dispatch_buffer itself:** routing, issue, invalid handling and the counter.

## Test plan
- **Reset and single issue:** after reset, push one ADD_SUB with alter_OV=1, `unit_id[0]` = 5'd9, ready high. Next cycle: `unit_valid` = 8'b0000_0001, `dispatched` = 1, `id_taken` = 9, `write_to_gpr` = 1, `alter_xer` = 1, `read_xer` = 1.
- **Backpressure fill:** DEPTH=4, `unit_ready` all 0, push 6 instructions back-to-back. `input_ready` drops after the 4th, `occupancy` = 4, the head holds stable. Release ready: 4 issues occur on consecutive cycles, in order.
- **Invalid retire:** push EXEC_LOAD. Next cycle: `invalid_instr` = 1, `unit_valid` = 0, `invalid_count` = 1. Preload the counter to 0xFFFF via 65535 invalid pushes; one more leaves it at 0xFFFF.
- **Flush:** flush with occupancy 3 and `input_valid` high. In that cycle: no `unit_valid`, no enqueue. Next cycle: `occupancy` = 0, `invalid_count` unchanged.
- **Mixed routing:** push MUL, COMPARE, SYSTEM(mtspr), ROTATE(sraw). Expect:
  - MUL: `unit_valid` bit 1.
  - COMPARE: bit 5, `write_to_cr` = 1, `read_xer` = 1.
  - SYSTEM(mtspr): bit 6, `write_to_spr` = 1.
  - ROTATE(sraw): bit 4, `alter_xer` = 1.
- **Async reset mid-stream:** with 2 entries queued, pull `rst_n` low between edges. `unit_valid` = 0 and `occupancy` = 0 immediately, without a clock edge.
